// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: opcodes, flag bit positions and CCR width.
package alu_pkg;

    localparam int CCR_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Flag positions inside a {C,V,N,Z} word.
    localparam int C_BIT = 3;
    localparam int V_BIT = 2;
    localparam int N_BIT = 1;
    localparam int Z_BIT = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus {C,V,N,Z}. C is carry for ADD/ADC and borrow
// for SUB/SBC/CMP. CMP reports SUB flags but passes A through as its result.
module alu_core
    import alu_pkg::*;
#(
    parameter int OP_SIZE = 4
) (
    input  logic [OP_SIZE-1:0] a,
    input  logic [OP_SIZE-1:0] b,
    input  logic [2:0]         op,
    input  logic               cin,
    output logic [OP_SIZE-1:0] r,
    output logic [CCR_W-1:0]   flags
);

    localparam int MSB = OP_SIZE - 1;

    logic [OP_SIZE:0]   wide;
    logic [OP_SIZE-1:0] calc;
    logic               c_flag;
    logic               v_flag;

    // Compute everything one bit wider so the carry/borrow falls out as bit OP_SIZE.
    always_comb begin
        wide   = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                wide = {1'b0, a} + {1'b0, b}
                     + ((op == OP_ADC) ? {{OP_SIZE{1'b0}}, cin} : '0);
                c_flag = wide[OP_SIZE];
                v_flag = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // A negative (OP_SIZE+1)-bit difference sets the top bit: borrow.
                wide = {1'b0, a} - {1'b0, b}
                     - ((op == OP_SBC) ? {{OP_SIZE{1'b0}}, cin} : '0);
                c_flag = wide[OP_SIZE];
                v_flag = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        calc = wide[OP_SIZE-1:0];
        r    = (op == OP_CMP) ? a : calc;
        flags        = '0;
        flags[C_BIT] = c_flag;
        flags[V_BIT] = v_flag;
        flags[N_BIT] = calc[MSB];
        flags[Z_BIT] = (calc == '0);
    end

endmodule

// File: rtl/alu_ccr_pipe.sv
// Registered ALU stage with an architectural CCR feeding carry into ADC/SBC.
// One cycle latency, one result per cycle when the consumer keeps up.
module alu_ccr_pipe
    import alu_pkg::*;
#(
    parameter int               OP_SIZE = 4,
    parameter logic [CCR_W-1:0] CCR_RST = 4'b0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [OP_SIZE-1:0] a,
    input  logic [OP_SIZE-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_SIZE-1:0] out_r,
    output logic [CCR_W-1:0]   out_ccr,
    output logic [CCR_W-1:0]   ccr,
    input  logic               ccr_wr,
    input  logic [CCR_W-1:0]   ccr_wdata
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high. The producer keeps valid and its payload steady until it transfers;
    // ready may depend combinationally on the consumer's ready (no loop back to valid).
    logic               accept;
    logic [OP_SIZE-1:0] core_r;
    logic [CCR_W-1:0]   core_flags;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    alu_core #(.OP_SIZE(OP_SIZE)) u_core (
        .a     (a),
        .b     (b),
        .op    (op),
        .cin   (ccr[C_BIT]),
        .r     (core_r),
        .flags (core_flags)
    );

    // Output register: load on accept, drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_ccr   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_r     <= core_r;
            out_ccr   <= core_flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Architectural CCR: an accepted op's flags take priority over a software load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccr <= CCR_RST;
        end else if (accept) begin
            ccr <= core_flags;
        end else if (ccr_wr) begin
            ccr <= ccr_wdata;
        end
    end

endmodule

// File: tb/tb_alu_ccr_pipe.sv
// Directed bench for alu_ccr_pipe (OP_SIZE=4) with hand-computed expectations.
module tb_alu_ccr_pipe;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_r;
    logic [3:0] out_ccr;
    logic [3:0] ccr;
    logic       ccr_wr;
    logic [3:0] ccr_wdata;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;

    alu_ccr_pipe #(.OP_SIZE(4), .CCR_RST(4'b0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_ccr   (out_ccr),
        .ccr       (ccr),
        .ccr_wr    (ccr_wr),
        .ccr_wdata (ccr_wdata)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers
    task automatic drive(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op       = OP_ADD;
        a        = $urandom_range(0, 15);
        b        = $urandom_range(0, 15);
    endtask

    // Advance one edge, leaving time 1 unit after it for sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); out_ready = 1'b1; ccr_wr = 1'b0; ccr_wdata = 4'b0;
        step(); step();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_r !== 4'b0000) begin n_fail++; $display("FAIL reset_out_r got=%b exp=0000", out_r); end
        n_cmp++; if (out_ccr !== 4'b0000) begin n_fail++; $display("FAIL reset_out_ccr got=%b exp=0000", out_ccr); end
        n_cmp++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL reset_ccr got=%b exp=0000", ccr); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        drive(OP_ADD, 4'd4, 4'd4);
        step(); idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_r !== 4'b1000) begin n_fail++; $display("FAIL add_out_r got=%b exp=1000", out_r); end
        n_cmp++; if (out_ccr !== 4'b0110) begin n_fail++; $display("FAIL add_out_ccr got=%b exp=0110", out_ccr); end
        n_cmp++; if (ccr !== 4'b0110) begin n_fail++; $display("FAIL add_ccr got=%b exp=0110", ccr); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 4'd8, 4'd8);
        step();
        n_cmp++; if (out_r !== 4'b0000) begin n_fail++; $display("FAIL b2b_add_r got=%b exp=0000", out_r); end
        n_cmp++; if (out_ccr !== 4'b1101) begin n_fail++; $display("FAIL b2b_add_ccr got=%b exp=1101", out_ccr); end
        drive(OP_SUB, 4'd3, 4'd5);
        step(); idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_r !== 4'b1110) begin n_fail++; $display("FAIL b2b_sub_r got=%b exp=1110", out_r); end
        n_cmp++; if (out_ccr !== 4'b1010) begin n_fail++; $display("FAIL b2b_sub_ccr got=%b exp=1010", out_ccr); end
        step();
    endtask

    task automatic test_adc_chain();
        drive(OP_ADD, 4'd15, 4'd1);
        step();
        n_cmp++; if (out_ccr !== 4'b1001) begin n_fail++; $display("FAIL adc_pre_ccr got=%b exp=1001", out_ccr); end
        drive(OP_ADC, 4'd1, 4'd1);
        step();
        n_cmp++; if (out_r !== 4'b0011) begin n_fail++; $display("FAIL adc_c1_r got=%b exp=0011", out_r); end
        n_cmp++; if (out_ccr !== 4'b0000) begin n_fail++; $display("FAIL adc_c1_ccr got=%b exp=0000", out_ccr); end
        drive(OP_ADD, 4'd1, 4'd1);
        step();
        drive(OP_ADC, 4'd1, 4'd1);
        step(); idle();
        n_cmp++; if (out_r !== 4'b0010) begin n_fail++; $display("FAIL adc_c0_r got=%b exp=0010", out_r); end
        step();
    endtask

    // Logic ops and signed-overflow corners, issued back to back.
    task automatic test_ops();
        logic [2:0] v_op[6]  = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SBC};
        logic [3:0] v_a[6]   = '{4'b1100, 4'b0000, 4'b1111, 4'd7, 4'd8, 4'd0};
        logic [3:0] v_b[6]   = '{4'b1010, 4'b0000, 4'b0101, 4'd1, 4'd1, 4'd0};
        // SUB 8-1 leaves C=0, so SBC 0-0 sees cin=0: result 0, flags 0001.
        logic [3:0] v_r[6]   = '{4'b1000, 4'b0000, 4'b1010, 4'b1000, 4'b0111, 4'b0000};
        logic [3:0] v_f[6]   = '{4'b0010, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            drive(v_op[i], v_a[i], v_b[i]);
            step();
            n_cmp++; if (out_r !== v_r[i]) begin n_fail++; $display("FAIL ops_r[%0d] got=%b exp=%b", i, out_r, v_r[i]); end
            n_cmp++; if (out_ccr !== v_f[i]) begin n_fail++; $display("FAIL ops_ccr[%0d] got=%b exp=%b", i, out_ccr, v_f[i]); end
        end
        idle();
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        exp_q.push_back(4'b0101);            // ADD 2+3
        exp_q.push_back(4'b1111);            // SUB 2-3
        drive(OP_ADD, 4'd2, 4'd3);
        step();
        drive(OP_SUB, 4'd2, 4'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        step(); step();
        exp_v = exp_q.pop_front();
        n_cmp++; if (out_r !== exp_v) begin n_fail++; $display("FAIL stall_hold_r got=%b exp=%b", out_r, exp_v); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid got=%b exp=1", out_valid); end
        n_cmp++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL stall_ccr got=%b exp=0000", ccr); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        step(); idle();
        exp_v = exp_q.pop_front();
        n_cmp++; if (out_r !== exp_v) begin n_fail++; $display("FAIL release_r got=%b exp=%b", out_r, exp_v); end
        n_cmp++; if (out_ccr !== 4'b1010) begin n_fail++; $display("FAIL release_ccr got=%b exp=1010", out_ccr); end
        n_cmp++; if (ccr !== 4'b1010) begin n_fail++; $display("FAIL release_live_ccr got=%b exp=1010", ccr); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_r !== 4'b1111) begin n_fail++; $display("FAIL drain_hold_r got=%b exp=1111", out_r); end
    endtask

    task automatic test_cmp_ccr_wr();
        drive(OP_CMP, 4'd5, 4'd5);
        step(); idle();
        n_cmp++; if (out_r !== 4'b0101) begin n_fail++; $display("FAIL cmp_r got=%b exp=0101", out_r); end
        n_cmp++; if (out_ccr !== 4'b0001) begin n_fail++; $display("FAIL cmp_ccr got=%b exp=0001", out_ccr); end
        ccr_wr = 1'b1; ccr_wdata = 4'b1000;
        step();
        ccr_wr = 1'b0;
        n_cmp++; if (ccr !== 4'b1000) begin n_fail++; $display("FAIL ccr_wr_load got=%b exp=1000", ccr); end
        n_cmp++; if (out_ccr !== 4'b0001) begin n_fail++; $display("FAIL ccr_wr_out_ccr got=%b exp=0001", out_ccr); end
        drive(OP_SBC, 4'd5, 4'd2);
        step();
        n_cmp++; if (out_r !== 4'b0010) begin n_fail++; $display("FAIL sbc_r got=%b exp=0010", out_r); end
        n_cmp++; if (out_ccr !== 4'b0000) begin n_fail++; $display("FAIL sbc_ccr got=%b exp=0000", out_ccr); end
        drive(OP_ADD, 4'd15, 4'd1);
        ccr_wr = 1'b1; ccr_wdata = 4'b1111;
        step(); idle();
        ccr_wr = 1'b0;
        n_cmp++; if (ccr !== 4'b1001) begin n_fail++; $display("FAIL ccr_wr_collide got=%b exp=1001", ccr); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(OP_ADD, 4'd4, 4'd4);
        step(); idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ccr got=%b exp=0000", ccr); end
        n_cmp++; if (out_r !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_r got=%b exp=0000", out_r); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
    endtask

    // Sequencer and final report
    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_adc_chain();
        test_ops();
        test_stall();
        test_cmp_ccr_wr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
